ps2_host_cmd_tx: RTL and testbench
==================================

// Module: ps2_host_cmd_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set, 0xFF reset) to the keyboard.
//  Shares PS2_CLK/PS2_DAT with PS2_Controller via open-drain enables; top level drives each line low when its oe=1, else Z.
//  Runs the inhibit / request-to-send / 11-clock frame / ACK sequence; reports done or error.
//  The receive path must ignore line activity while busy=1.
// PARAMETERS
//  INHIBIT_CYCLES    6000     clock-low hold before RTS (120 us @ 50 MHz)
//  TIMEOUT_CYCLES    750000   max cycles from clock release to ACK sampled (15 ms)
//  FA_TIMEOUT_CYCLES 1000000  max wait for device response byte (20 ms, PS2_TX_FA_WAIT_EN only)
// PORTS
//  CLOCK_50    in   1  system clock
//  resetn      in   1  async active-low reset
//  cmd_data    in   8  byte to send
//  cmd_valid   in   1  request; accepted when cmd_valid & cmd_ready
//  cmd_ready   out  1  1 in IDLE only
//  ps2_clk_in  in   1  raw PS2_CLK line level
//  ps2_dat_in  in   1  raw PS2_DAT line level
//  ps2_clk_oe  out  1  1 = pull PS2_CLK low
//  ps2_dat_oe  out  1  1 = pull PS2_DAT low
//  rx_data     in   8  byte from PS2_Controller received_data
//  rx_valid    in   1  PS2_Controller received_data_en
//  busy        out  1  1 in any state except IDLE
//  done        out  1  one-cycle pulse: byte sent and acknowledged
//  error       out  1  one-cycle pulse: failure; err_code valid same cycle
//  err_code    out  2  01 timeout, 10 NACK (ack bit high), 11 resend (0xFE)
// BEHAVIOUR
//  Reset (async): IDLE; cmd_ready=1; busy, done, error, oe outputs = 0; err_code=00. Lines released immediately, any phase.
//  Line inputs pass 2-FF synchronisers; fall = sync clk 1->0, rise = 0->1.
//  Parity: odd, i.e. ~^cmd_data, latched at accept with the data byte.
//  IDLE: on accept -> INHIBIT next cycle; clk_oe=1; cycle counter cleared.
//  INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles; then dat_oe=1 (start bit 0) for one cycle with clk still low -> REQ.
//  REQ: clk_oe=0, dat_oe=1; timeout counter starts. Edge counter n=0.
//  DATA: on each fall n++; host sets the line after fall n:
//   n=1..8 dat_oe = ~data[n-1] (LSB first); n=9 dat_oe = ~parity; n=10 dat_oe=0 (stop).
//   n=11 -> ACK.
//  ACK: on next rise, sample sync data: 0 = ACK, 1 = NACK (error, code 10).
//   After ACK, wait until sync clk=1 and sync data=1, then done (or WAIT_FA if enabled).
//  Timeout: counter >= TIMEOUT_CYCLES before ACK sampled -> error, code 01.
//  Any error: oe outputs 0, then IDLE. done/error pulse for one cycle, then IDLE.
//  cmd_valid while busy: ignored, not queued. err_code holds until the next error or reset.
//  done and error never assert in the same cycle.
// CONFIGURATION
//  PS2_TX_FA_WAIT_EN defined: after line idle -> WAIT_FA; timeout counter cleared.
//   rx_valid & rx_data==8'hFA -> done. rx_valid & 8'hFE -> error, code 11.
//   Other bytes are ignored. No response in FA_TIMEOUT_CYCLES -> error, code 01.
//  Undefined: done at line idle after ACK; rx_data/rx_valid unused (ports kept).
// TESTING
//  T1 send 0xED, device model acks: clk low >=6000 cycles;
//     bits seen by device = 1,0,1,1,0,1,1,1, parity 1, stop 1; done=1 one cycle; err none.
//  T2 send 0x01: parity bit 0; send 0xFF: parity 1; both done.
//  T3 device never clocks after release: error=1, err_code=01 at TIMEOUT_CYCLES;
//     both oe 0; cmd_ready=1 next cycle.
//  T4 device holds data high at ack clock: error=1, err_code=10; no done pulse.
//  T5 resetn low during bit 4 of DATA: oe outputs 0 immediately;
//     after release cmd_ready=1, no done/error pulse.
//  T6 PS2_TX_FA_WAIT_EN: rx 0xAA then 0xFA -> done only on 0xFA;
//     separate run rx 0xFE -> error, err_code=11.

Source files
------------

// File: rtl/ps2_host_cmd_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-clock frame, ACK check.
// Optional build macro PS2_TX_FA_WAIT_EN: also wait for the device 0xFA/0xFE response byte.
module ps2_host_cmd_tx #(
   parameter int unsigned INHIBIT_CYCLES    = 6000,
   parameter int unsigned TIMEOUT_CYCLES    = 750000,
   parameter int unsigned FA_TIMEOUT_CYCLES = 1000000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code
);

   localparam int unsigned MAX_A   = (TIMEOUT_CYCLES > FA_TIMEOUT_CYCLES) ? TIMEOUT_CYCLES : FA_TIMEOUT_CYCLES;
   localparam int unsigned MAX_CNT = (MAX_A > INHIBIT_CYCLES) ? MAX_A : INHIBIT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_INHIBIT, S_START, S_REQ, S_DATA, S_ACK, S_LINE_IDLE, S_WAIT_FA, S_PULSE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_q, bit_d, bit_nxt;
   logic [7:0]       data_q, data_d;
   logic             parity_q, parity_d;
   logic             clk_oe_d, dat_oe_d, done_d, error_d;
   logic [1:0]       err_code_d, err_val;
   logic             err_set, done_set, timed_out;

   logic [2:0] clk_sr;
   logic [1:0] dat_sr;
   logic       clk_sync, clk_prev, dat_sync, clk_fall, clk_rise;

`ifndef PS2_TX_FA_WAIT_EN
   logic unused_rx;
   assign unused_rx = ^{rx_data, rx_valid};
`endif

   // Two-flop synchronisers plus one stage of history for edge detection
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         clk_sr <= 3'b111;
         dat_sr <= 2'b11;
      end else begin
         clk_sr <= {clk_sr[1:0], ps2_clk_in};
         dat_sr <= {dat_sr[0], ps2_dat_in};
      end
   end

   assign clk_sync  = clk_sr[1];
   assign clk_prev  = clk_sr[2];
   assign dat_sync  = dat_sr[1];
   assign clk_fall  = clk_prev & ~clk_sync;
   assign clk_rise  = ~clk_prev & clk_sync;
   assign timed_out = (cnt_q >= CNT_W'(TIMEOUT_CYCLES));

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         data_q     <= '0;
         parity_q   <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         err_code   <= 2'b00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         data_q     <= data_d;
         parity_q   <= parity_d;
         ps2_clk_oe <= clk_oe_d;
         ps2_dat_oe <= dat_oe_d;
         cmd_ready  <= (state_d == S_IDLE);
         busy       <= (state_d != S_IDLE);
         done       <= done_d;
         error      <= error_d;
         err_code   <= err_code_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      data_d     = data_q;
      parity_d   = parity_q;
      clk_oe_d   = 1'b0;
      dat_oe_d   = ps2_dat_oe;
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_code_d = err_code;
      err_set    = 1'b0;
      err_val    = 2'b00;
      done_set   = 1'b0;
      bit_nxt    = bit_q + 4'd1;

      case (state_q)
         S_IDLE: begin
            dat_oe_d = 1'b0;
            if (cmd_valid && cmd_ready) begin
               state_d  = S_INHIBIT;
               data_d   = cmd_data;
               parity_d = ~^cmd_data;
               cnt_d    = '0;
               clk_oe_d = 1'b1;
            end
         end
         S_INHIBIT: begin
            clk_oe_d = 1'b1;
            dat_oe_d = 1'b0;
            if (cnt_q >= CNT_W'(INHIBIT_CYCLES - 1)) begin
               state_d  = S_START;
               dat_oe_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         // Start bit already low: release the clock and let the device take over
         S_START: begin
            dat_oe_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_REQ;
         end
         S_REQ: begin
            dat_oe_d = 1'b1;
            if (timed_out) begin
               err_set = 1'b1;
               err_val = 2'b01;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (clk_fall) begin
                  bit_d    = 4'd1;
                  dat_oe_d = ~data_q[0];
                  state_d  = S_DATA;
               end
            end
         end
         // Falls 2..8 shift data, 9 parity, 10 stop (released), 11 hands over to ACK
         S_DATA: begin
            if (timed_out) begin
               err_set = 1'b1;
               err_val = 2'b01;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (clk_fall) begin
                  bit_d = bit_nxt;
                  if (bit_nxt <= 4'd8) begin
                     dat_oe_d = ~data_q[3'(bit_nxt - 4'd1)];
                  end else if (bit_nxt == 4'd9) begin
                     dat_oe_d = ~parity_q;
                  end else begin
                     dat_oe_d = 1'b0;
                     if (bit_nxt == 4'd11) state_d = S_ACK;
                  end
               end
            end
         end
         S_ACK: begin
            dat_oe_d = 1'b0;
            if (timed_out) begin
               err_set = 1'b1;
               err_val = 2'b01;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (clk_rise) begin
                  if (dat_sync) begin
                     err_set = 1'b1;
                     err_val = 2'b10;
                  end else begin
                     state_d = S_LINE_IDLE;
                  end
               end
            end
         end
         S_LINE_IDLE: begin
            dat_oe_d = 1'b0;
            if (clk_sync && dat_sync) begin
`ifdef PS2_TX_FA_WAIT_EN
               state_d = S_WAIT_FA;
               cnt_d   = '0;
`else
               done_set = 1'b1;
`endif
            end
         end
`ifdef PS2_TX_FA_WAIT_EN
         // Only the device response byte matters here; anything else is ignored
         S_WAIT_FA: begin
            dat_oe_d = 1'b0;
            cnt_d    = cnt_q + CNT_W'(1);
            if (rx_valid && (rx_data == 8'hFA)) begin
               done_set = 1'b1;
            end else if (rx_valid && (rx_data == 8'hFE)) begin
               err_set = 1'b1;
               err_val = 2'b11;
            end else if (cnt_q >= CNT_W'(FA_TIMEOUT_CYCLES)) begin
               err_set = 1'b1;
               err_val = 2'b01;
            end
         end
`endif
         S_PULSE: begin
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: begin
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase

      if (err_set) begin
         state_d    = S_PULSE;
         error_d    = 1'b1;
         err_code_d = err_val;
         clk_oe_d   = 1'b0;
         dat_oe_d   = 1'b0;
      end else if (done_set) begin
         state_d  = S_PULSE;
         done_d   = 1'b1;
         clk_oe_d = 1'b0;
         dat_oe_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_host_cmd_tx.sv
// Bench for ps2_host_cmd_tx: open-drain bus with a PS/2 device model and a cycle-level outcome model.
module tb_ps2_host_cmd_tx;
   localparam int INH   = 100;
   localparam int TMO   = 1500;
   localparam int FATMO = 2000;
   localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2, M_RESET = 3, M_RESEND = 4;
   // Outcome encoding: 0 done, 4+code for error, 9 no pulse at all
   localparam int O_DONE = 0, O_TMO = 5, O_NACK = 6, O_RESEND = 7, O_NONE = 9;

   logic       CLOCK_50 = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] cmd_data = '0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
   logic [1:0] err_code;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
   logic       clk_line, dat_line;

   int checks = 0, failures = 0;
   int cyc = 0, m_state = 0, m_acc = 0, m_exp = O_NONE, m_code = 0, s;
   bit ended;

   assign clk_line = !(ps2_clk_oe || dev_clk_low);
   assign dat_line = !(ps2_dat_oe || dev_dat_low);

   ps2_host_cmd_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FA_TIMEOUT_CYCLES(FATMO)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .ps2_clk_in(clk_line), .ps2_dat_in(dat_line),
      .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy), .done(done), .error(error), .err_code(err_code));

   always #5 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic chk_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame the device should see: data LSB first, odd parity, stop=1
   function automatic int frame_of(input logic [7:0] d);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += (d >> i) & 1;
      return (1 << 9) | (((ones % 2) == 0 ? 1 : 0) << 8) | int'(d);
   endfunction

   // Cycle model: outputs derived from cycles since accept and the expected outcome
   always @(negedge CLOCK_50) begin
      ended = 1'b0;
      if (!resetn) begin
         m_state = 0;
         m_code  = 0;
      end else if (m_state == 0) begin
         chk_eq("idle_busy", int'(busy), 0);
         chk_eq("idle_ready", int'(cmd_ready), 1);
         chk_eq("idle_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
         chk_eq("idle_pulse", int'({done, error}), 0);
         chk_eq("idle_err_code", int'(err_code), m_code);
      end else begin
         s = cyc - m_acc;
         if (done || error) begin
            chk_eq("pulse_excl", int'(done & error), 0);
            chk_eq("outcome", error ? 4 + int'(err_code) : O_DONE, m_exp);
            if (m_exp == O_TMO) chk_eq("timeout_cycle", s, INH + 2 + TMO);
            chk_eq("pulse_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
            chk_eq("pulse_busy", int'(busy), 1);
            chk_eq("pulse_ready", int'(cmd_ready), 0);
            if (m_exp >= O_TMO && m_exp <= O_RESEND) m_code = m_exp - 4;
            m_state = 0;
            ended = 1'b1;
         end else begin
            chk_eq("busy", int'(busy), 1);
            chk_eq("ready", int'(cmd_ready), 0);
            if (s < INH) begin
               chk_eq("inhibit_oe", int'({ps2_clk_oe, ps2_dat_oe}), 2);
            end else if (s == INH) begin
               chk_eq("start_oe", int'({ps2_clk_oe, ps2_dat_oe}), 3);
            end else if (s == INH + 1) begin
               chk_eq("rts_oe", int'({ps2_clk_oe, ps2_dat_oe}), 1);
            end else begin
               chk_eq("clk_released", int'(ps2_clk_oe), 0);
            end
            if (m_exp == O_TMO && s == INH + 2 + TMO) chk_eq("timeout_late", int'(error), 1);
         end
      end
      if (resetn && !ended && m_state == 0 && cmd_valid) begin
         m_state = 1;
         m_acc   = cyc + 1;
      end
   end

   task automatic pulse_rx(input logic [7:0] b);
      @(posedge CLOCK_50); #1;
      rx_data = b; rx_valid = 1'b1;
      @(posedge CLOCK_50); #1;
      rx_valid = 1'b0;
   endtask

   // PS/2 device: waits for RTS, clocks 11 pulses, samples on each rise, drives ACK
   task automatic device_frame(input int h, input int mode, output logic [9:0] got);
      int n = 0;
      got = '0;
      while (!(clk_line && !dat_line) && n < INH + 50) begin
         @(negedge CLOCK_50);
         n++;
      end
      chk_eq("rts_seen", int'(n < INH + 50), 1);
      if (mode == M_SILENT) return;
      repeat (5) @(negedge CLOCK_50);
      for (int i = 1; i <= 11; i++) begin
         dev_clk_low = 1'b1;
         if (i == 3) begin
            // Mid-frame noise: a second command and a 0xFE byte must both be ignored
            @(posedge CLOCK_50); #1;
            cmd_data = 8'($urandom); cmd_valid = 1'b1; rx_data = 8'hFE; rx_valid = 1'b1;
            @(posedge CLOCK_50); #1;
            cmd_valid = 1'b0; rx_valid = 1'b0;
            repeat (h - 2) @(negedge CLOCK_50);
         end else if (i == 5 && mode == M_RESET) begin
            repeat (h / 2) @(negedge CLOCK_50);
            resetn = 1'b0;
            #1;
            chk_eq("reset_oe_immediate", int'({ps2_clk_oe, ps2_dat_oe}), 0);
            chk_eq("reset_busy_immediate", int'(busy), 0);
            dev_clk_low = 1'b0;
            repeat (3) @(negedge CLOCK_50);
            @(posedge CLOCK_50); #1;
            resetn = 1'b1;
            return;
         end else if (i == 11) begin
            repeat (h / 2) @(negedge CLOCK_50);
            if (mode != M_NACK) dev_dat_low = 1'b1;
            repeat (h - h / 2) @(negedge CLOCK_50);
         end else begin
            repeat (h) @(negedge CLOCK_50);
         end
         dev_clk_low = 1'b0;
         if (i <= 10) got[i-1] = dat_line;
         repeat (h) @(negedge CLOCK_50);
         dev_dat_low = 1'b0;
      end
   endtask

   task automatic run_cmd(input logic [7:0] d, input int mode, input int h, output logic [9:0] got);
      int n = 0;
      case (mode)
         M_NACK:   m_exp = O_NACK;
         M_SILENT: m_exp = O_TMO;
         M_RESET:  m_exp = O_NONE;
         M_RESEND: m_exp = O_RESEND;
         default:  m_exp = O_DONE;
      endcase
      repeat (3) @(posedge CLOCK_50);
      #1;
      cmd_data = d; cmd_valid = 1'b1;
      @(posedge CLOCK_50); #1;
      cmd_valid = 1'b0;
      device_frame(h, mode, got);
      if (mode == M_ACK || mode == M_NACK || mode == M_RESEND) chk_eq("frame_bits", int'(got), frame_of(d));
`ifdef PS2_TX_FA_WAIT_EN
      if (mode == M_ACK) begin
         repeat (8) @(posedge CLOCK_50);
         pulse_rx(8'hAA);
         repeat (10) @(posedge CLOCK_50);
         chk_eq("busy_after_aa", int'(busy), 1);
         pulse_rx(8'hFA);
      end else if (mode == M_RESEND) begin
         repeat (8) @(posedge CLOCK_50);
         pulse_rx(8'hFE);
      end
`endif
      while (m_state != 0 && n < INH + TMO + FATMO + 2000) begin
         @(posedge CLOCK_50);
         n++;
      end
      chk_eq("txn_end", m_state, 0);
      if (mode == M_RESET) repeat (50) @(posedge CLOCK_50);
      repeat (2) @(posedge CLOCK_50);
   endtask

   initial begin
      logic [9:0] got;
      int mode;
      repeat (3) @(posedge CLOCK_50);
      #1;
      chk_eq("rst_ready", int'(cmd_ready), 1);
      chk_eq("rst_busy", int'(busy), 0);
      chk_eq("rst_pulses", int'({done, error}), 0);
      chk_eq("rst_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
      chk_eq("rst_err_code", int'(err_code), 0);
      resetn = 1'b1;

      run_cmd(8'hED, M_ACK, 20, got);
      chk_eq("t1_frame_ED", int'(got), 10'h3ED);
      run_cmd(8'h01, M_ACK, 15, got);
      chk_eq("t2_frame_01", int'(got), 10'h201);
      run_cmd(8'hFF, M_ACK, 25, got);
      chk_eq("t2_frame_FF", int'(got), 10'h3FF);
      run_cmd(8'h5A, M_SILENT, 20, got);
      chk_eq("t3_err_code", int'(err_code), 1);
      run_cmd(8'hA3, M_NACK, 18, got);
      chk_eq("t4_err_code", int'(err_code), 2);
      run_cmd(8'h3C, M_RESET, 20, got);
      chk_eq("t5_ready", int'(cmd_ready), 1);
`ifdef PS2_TX_FA_WAIT_EN
      run_cmd(8'hF4, M_RESEND, 20, got);
      chk_eq("t6_err_code", int'(err_code), 3);
`endif
      for (int k = 0; k < 16; k++) begin
         mode = int'($urandom_range(0, 3));
`ifdef PS2_TX_FA_WAIT_EN
         if (mode == 3) mode = M_RESEND;
`else
         if (mode == 3) mode = M_ACK;
`endif
         if (mode == 2) mode = M_ACK;
         run_cmd(8'($urandom), mode, int'($urandom_range(10, 40)), got);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
